// File: rtl/bnn_eval_sequencer.sv
// bnn_eval_sequencer: clocked engine that streams testcases into a BNN classifier and scores predictions.
// Define BNN_EVAL_CONFUSION_EN to build the label x prediction confusion counters.
module bnn_eval_sequencer #(
    parameter int FEAT_CNT      = 19,
    parameter int FEAT_BITS     = 4,
    parameter int CLASS_CNT     = 3,
    parameter int TEST_CNT      = 1000,
    parameter int SETTLE_CYCLES = 4,
    localparam int CW = $clog2(CLASS_CNT),
    localparam int AW = (TEST_CNT > 1) ? $clog2(TEST_CNT) : 1,
    localparam int NW = $clog2(TEST_CNT + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic [AW-1:0]                 mem_addr,
    input  logic [FEAT_CNT*FEAT_BITS-1:0] mem_feat,
    input  logic [CW-1:0]                 mem_label,
    output logic [FEAT_CNT*FEAT_BITS-1:0] features,
    input  logic [CW-1:0]                 prediction,
    output logic                          busy,
    output logic                          done,
    output logic                          res_valid,
    output logic [AW-1:0]                 res_idx,
    output logic [CW-1:0]                 res_pred,
    output logic                          res_hit,
    output logic [NW-1:0]                 correct_cnt,
    output logic [NW-1:0]                 invalid_cnt,
    input  logic [2*CW-1:0]               conf_sel,
    output logic [NW-1:0]                 conf_count
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW:0] CC = (CW + 1)'(CLASS_CNT);
    localparam logic [AW-1:0] LAST = AW'(TEST_CNT - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SETTLE, CAPTURE, DONE} state_t;
    state_t state;
    logic [SW-1:0] scnt;
    logic [CW-1:0] label;
    logic pred_bad, pred_hit;

    assign pred_bad = {1'b0, prediction} >= CC;
    assign pred_hit = !pred_bad && prediction == label;

    // mem_addr doubles as the testcase index; the result is sampled on the last settle edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_addr    <= '0;
            features    <= '0;
            label       <= '0;
            scnt        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            res_valid   <= 1'b0;
            res_idx     <= '0;
            res_pred    <= '0;
            res_hit     <= 1'b0;
            correct_cnt <= '0;
            invalid_cnt <= '0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE, DONE: if (start) begin
                    correct_cnt <= '0;
                    invalid_cnt <= '0;
                    mem_addr    <= '0;
                    busy        <= 1'b1;
                    done        <= 1'b0;
                    state       <= FETCH;
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    features <= mem_feat;
                    label    <= mem_label;
                    scnt     <= SW'(SETTLE_CYCLES - 1);
                    state    <= SETTLE;
                end
                SETTLE: if (scnt == '0) begin
                    res_valid   <= 1'b1;
                    res_idx     <= mem_addr;
                    res_pred    <= prediction;
                    res_hit     <= pred_hit;
                    correct_cnt <= correct_cnt + NW'(pred_hit);
                    invalid_cnt <= invalid_cnt + NW'(pred_bad);
                    state       <= CAPTURE;
                end else begin
                    scnt <= scnt - 1'b1;
                end
                CAPTURE: if (mem_addr == LAST) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end else begin
                    mem_addr <= mem_addr + 1'b1;
                    state    <= FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BNN_EVAL_CONFUSION_EN
    logic [NW-1:0] cell [CLASS_CNT][CLASS_CNT];
    logic [CW-1:0] sel_l, sel_p;
    logic clr, smp;
    assign clr   = start && (state == IDLE || state == DONE);
    assign smp   = state == SETTLE && scnt == '0;
    assign sel_l = conf_sel[2*CW-1:CW];
    assign sel_p = conf_sel[CW-1:0];
    always_ff @(posedge clk)
        for (int l = 0; l < CLASS_CNT; l++)
            for (int p = 0; p < CLASS_CNT; p++)
                if (rst || clr) cell[l][p] <= '0;
                else if (smp && !pred_bad && label == CW'(l) && prediction == CW'(p)) cell[l][p] <= cell[l][p] + 1'b1;
    assign conf_count = ({1'b0, sel_l} < CC && {1'b0, sel_p} < CC) ? cell[sel_l][sel_p] : '0;
`else
    logic unused_conf;
    assign unused_conf = ^conf_sel;
    assign conf_count  = '0;
`endif
endmodule
